// File: rtl/char_motion_ctrl.sv
// Per-character motion controller: walk, jump, fall, land and respawn with sprite animation control.
// Optional VAR_JUMP_EN: releasing jump while rising ends the jump early (short hop).
module char_motion_ctrl #(
    parameter int X_W         = 11,
    parameter int Y_W         = 10,
    parameter int CNT_W       = 20,
    parameter int SCREEN_W    = 1024,
    parameter int SCREEN_H    = 768,
    parameter int CHAR_W      = 64,
    parameter int CHAR_H      = 64,
    parameter int SPAWN_X     = 500,
    parameter int SPAWN_Y     = SCREEN_H - 2 - CHAR_H,
    parameter int JUMP_HEIGHT = 200,
    parameter int WALK_DIV    = 400_000,
    parameter int AIR_DIV     = 700_000,
    parameter int JUMP_DIV0   = 200_000,
    parameter int JUMP_STEP   = 40_000,
    parameter int FALL_DIV0   = 800_000,
    parameter int FALL_STEP   = 10_000,
    parameter int FALL_MIN    = 150_000,
    parameter int ANIM_FRAMES = 8,
    parameter int ANIM_PX     = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           left,
    input  logic           right,
    input  logic           jump,
    input  logic           on_platform,
    input  logic           hit_ceiling,
    input  logic           respawn,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [6:0]     sprite_control,
    output logic [2:0]     state,
    output logic           landed
);

    localparam int FLOOR = SCREEN_H - 1 - CHAR_H;
    localparam int X_MAX = SCREEN_W - CHAR_W;

    typedef enum logic [2:0] {
        S_SPAWN   = 3'd0,
        S_IDLE    = 3'd1,
        S_MOVING  = 3'd2,
        S_JUMPING = 3'd3,
        S_FALLING = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [Y_W-1:0]     y_start_q, y_start_d;
    logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0]   v_per_q, v_per_d;
    logic [6:0]         ctrl_q, ctrl_d;
    logic               landed_q, landed_d;

    logic               dir_valid;
    logic               air;
    logic               jump_release;
    logic               rise_done;
    logic [CNT_W-1:0]   h_div;
    logic [X_W-1:0]     x_next;
    logic               x_blocked;
    logic               dir_right_d;
    logic [3:0]         frame_d;

    assign dir_valid = left ^ right;
    assign air       = (state_q == S_JUMPING) || (state_q == S_FALLING);
    assign rise_done = (y_start_q - y_q) >= Y_W'(JUMP_HEIGHT);
    assign h_div     = (state_q == S_MOVING) ? CNT_W'(WALK_DIV) : CNT_W'(AIR_DIV);
    assign x_next    = right ? (x_q + X_W'(1)) : (x_q - X_W'(1));
    assign x_blocked = right ? (x_q >= X_W'(X_MAX)) : (x_q == '0);

`ifdef VAR_JUMP_EN
    assign jump_release = !jump;
`else
    assign jump_release = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        y_start_d   = y_start_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        v_per_d     = v_per_q;
        landed_d    = 1'b0;
        dir_right_d = ctrl_q[6];
        frame_d     = ctrl_q[3:0];

        if (respawn) begin
            state_d = S_SPAWN;
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else begin
            case (state_q)
                S_SPAWN: begin
                    x_d         = X_W'(SPAWN_X);
                    y_d         = Y_W'(SPAWN_Y);
                    dir_right_d = 1'b1;
                    frame_d     = '0;
                    h_cnt_d     = '0;
                    v_cnt_d     = '0;
                    state_d     = S_IDLE;
                end
                S_IDLE: begin
                    h_cnt_d = '0;
                    if (jump) begin
                        state_d   = S_JUMPING;
                        y_start_d = y_q;
                        v_cnt_d   = '0;
                        v_per_d   = CNT_W'(JUMP_DIV0);
                    end else if (dir_valid) begin
                        state_d = S_MOVING;
                    end
                end
                S_MOVING: begin
                    if (jump) begin
                        state_d   = S_JUMPING;
                        y_start_d = y_q;
                        v_cnt_d   = '0;
                        v_per_d   = CNT_W'(JUMP_DIV0);
                    end else if (!on_platform && (y_q != Y_W'(FLOOR))) begin
                        state_d = S_FALLING;
                        v_cnt_d = '0;
                        v_per_d = CNT_W'(FALL_DIV0);
                    end else if (!dir_valid) begin
                        state_d = S_IDLE;
                    end
                end
                S_JUMPING: begin
                    // The fall keeps the current rise period so the apex feels continuous.
                    if (rise_done || hit_ceiling || jump_release) begin
                        state_d = S_FALLING;
                        v_cnt_d = '0;
                    end else if (v_cnt_q >= v_per_q) begin
                        v_cnt_d = '0;
                        if (y_q == '0) begin
                            state_d = S_FALLING;
                        end else begin
                            y_d     = y_q - Y_W'(1);
                            v_per_d = (v_per_q >= CNT_W'(FALL_DIV0 - JUMP_STEP)) ?
                                      CNT_W'(FALL_DIV0) : v_per_q + CNT_W'(JUMP_STEP);
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + CNT_W'(1);
                    end
                end
                S_FALLING: begin
                    if (on_platform || (y_q == Y_W'(FLOOR))) begin
                        state_d  = S_IDLE;
                        landed_d = 1'b1;
                    end else if (v_cnt_q >= v_per_q) begin
                        v_cnt_d = '0;
                        y_d     = (y_q >= Y_W'(FLOOR)) ? Y_W'(FLOOR) : y_q + Y_W'(1);
                        v_per_d = (v_per_q >= CNT_W'(FALL_MIN + FALL_STEP)) ?
                                  v_per_q - CNT_W'(FALL_STEP) : CNT_W'(FALL_MIN);
                    end else begin
                        v_cnt_d = v_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_SPAWN;
            endcase

            // A step into a wall still restarts the divider but neither moves nor animates.
            if ((state_q == S_MOVING) || air) begin
                if (!dir_valid) begin
                    h_cnt_d = '0;
                end else begin
                    dir_right_d = right;
                    if (h_cnt_q >= h_div) begin
                        h_cnt_d = '0;
                        if (!x_blocked) begin
                            x_d = x_next;
                            if (air || ((x_next % X_W'(ANIM_PX)) == '0)) begin
                                frame_d = (frame_d == 4'(ANIM_FRAMES - 1)) ? 4'd0 : frame_d + 4'd1;
                            end
                        end
                    end else begin
                        h_cnt_d = h_cnt_q + CNT_W'(1);
                    end
                end
            end
        end

        ctrl_d = {dir_right_d,
                  (state_d == S_JUMPING) || (state_d == S_FALLING),
                  (state_d == S_IDLE) || (state_d == S_SPAWN),
                  frame_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_SPAWN;
            x_q       <= '0;
            y_q       <= '0;
            y_start_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            v_per_q   <= '0;
            ctrl_q    <= 7'b1010000;
            landed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            y_start_q <= y_start_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            v_per_q   <= v_per_d;
            ctrl_q    <= ctrl_d;
            landed_q  <= landed_d;
        end
    end

    assign x              = x_q;
    assign y              = y_q;
    assign sprite_control = ctrl_q;
    assign state          = state_q;
    assign landed         = landed_q;

endmodule
